// File: rtl/corescore_reset_seq.sv
// Reset sequencer: qualifies a PLL/MMCM lock, then releases core and peripheral
// resets in order, and counts lock losses that occur after core release.
module corescore_reset_seq #(
    parameter int unsigned STABLE_CYCLES = 1024,
    parameter int unsigned STAGE_CYCLES  = 16,
    parameter int unsigned LOSS_W        = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_locked,
    output logic              o_rst_core,
    output logic              o_rst_periph,
    output logic              o_ready,
    output logic [LOSS_W-1:0] o_lock_losses,
    output logic [1:0]        o_state
);

    localparam int unsigned MAX_CYCLES =
        (STABLE_CYCLES > STAGE_CYCLES) ? STABLE_CYCLES : STAGE_CYCLES;
    localparam int unsigned CNT_W = $clog2(MAX_CYCLES);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] STAGE_LAST  = CNT_W'(STAGE_CYCLES - 1);

    typedef enum logic [1:0] {
        StHold   = 2'd0,
        StStable = 2'd1,
        StStage  = 2'd2,
        StRun    = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [LOSS_W-1:0] loss_q, loss_d;
    logic [1:0]        sync_q;
    logic              locked_s;
    logic              loss_inc;

    // i_locked is asynchronous; only sync_q[0] may sample it
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], i_locked};
        end
    end

    assign locked_s = sync_q[1];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= StHold;
            cnt_q   <= '0;
            loss_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            loss_q  <= loss_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        loss_inc = 1'b0;
        unique case (state_q)
            StHold: begin
                if (locked_s) begin
                    state_d = StStable;
                    cnt_d   = '0;
                end
            end
            StStable: begin
                // Lock drop wins over terminal count; not a loss, core never ran
                if (!locked_s) begin
                    state_d = StHold;
                    cnt_d   = '0;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d = StStage;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StStage: begin
                if (!locked_s) begin
                    state_d  = StHold;
                    cnt_d    = '0;
                    loss_inc = 1'b1;
                end else if (cnt_q == STAGE_LAST) begin
                    state_d = StRun;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StRun: begin
                if (!locked_s) begin
                    state_d  = StHold;
                    cnt_d    = '0;
                    loss_inc = 1'b1;
                end
            end
        endcase
    end

    always_comb begin
        loss_d = loss_q;
        if (loss_inc && (loss_q != {LOSS_W{1'b1}})) begin
            loss_d = loss_q + 1'b1;
        end
    end

    assign o_rst_core    = (state_q == StHold) || (state_q == StStable);
    assign o_rst_periph  = (state_q != StRun);
    assign o_ready       = (state_q == StRun);
    assign o_lock_losses = loss_q;
    assign o_state       = state_q;

endmodule

// File: tb/tb_corescore_reset_seq.sv
// Directed bench for corescore_reset_seq with STABLE_CYCLES=8, STAGE_CYCLES=4, LOSS_W=2.
module tb_corescore_reset_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       locked = 1'b0;
    logic       rst_core, rst_periph, ready;
    logic [1:0] losses;
    logic [1:0] state;

    int n_tests = 0;
    int n_fail  = 0;

    corescore_reset_seq #(
        .STABLE_CYCLES(8),
        .STAGE_CYCLES (4),
        .LOSS_W       (2)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_locked     (locked),
        .o_rst_core   (rst_core),
        .o_rst_periph (rst_periph),
        .o_ready      (ready),
        .o_lock_losses(losses),
        .o_state      (state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       locked;
        int         cycles;
        logic [1:0] st;
        logic       core;
        logic       periph;
        logic       rdy;
        logic [1:0] loss;
    } vec_t;

    vec_t vecs[24];

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string name, input logic [1:0] st, input logic core,
                         input logic periph, input logic rdy, input logic [1:0] loss);
        n_tests++;
        if (state !== st || rst_core !== core || rst_periph !== periph || ready !== rdy ||
            losses !== loss) begin
            n_fail++;
            $display("FAIL %s: got state=%0d core=%b periph=%b ready=%b losses=%0d, want state=%0d core=%b periph=%b ready=%b losses=%0d",
                     name, state, rst_core, rst_periph, ready, losses, st, core, periph, rdy, loss);
        end
    endtask

    task automatic wait_state(input string name, input logic [1:0] target, input int budget);
        int i;
        i = 0;
        while (state !== target && i < budget) begin
            step(1);
            i++;
        end
        n_tests++;
        if (state !== target) begin
            n_fail++;
            $display("FAIL %s: timeout, got state=%0d want state=%0d", name, state, target);
        end
    endtask

    // Core and peripheral resets must never release together, and periph never before core
    logic prev_core = 1'b1, prev_periph = 1'b1;
    always @(negedge clk) begin
        if (rst_core === 1'b1 && rst_periph === 1'b0) begin
            n_fail++;
            $display("FAIL order: got core=%b periph=%b, periph released while core held",
                     rst_core, rst_periph);
        end
        if (prev_core && prev_periph && rst_core === 1'b0 && rst_periph === 1'b0) begin
            n_fail++;
            $display("FAIL same_cycle: got core=0 periph=0 from both 1, want staged release");
        end
        prev_core   <= rst_core;
        prev_periph <= rst_periph;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, want finish before 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        // Power-up: lock first sampled at edge 10, core release after 20, run after 24
        vecs[0]  = '{1'b1, 1'b0, 3, 2'd0, 1'b1, 1'b1, 1'b0, 2'd0};
        vecs[1]  = '{1'b0, 1'b0, 6, 2'd0, 1'b1, 1'b1, 1'b0, 2'd0};
        vecs[2]  = '{1'b0, 1'b1, 2, 2'd0, 1'b1, 1'b1, 1'b0, 2'd0};
        vecs[3]  = '{1'b0, 1'b1, 1, 2'd1, 1'b1, 1'b1, 1'b0, 2'd0};
        vecs[4]  = '{1'b0, 1'b1, 7, 2'd1, 1'b1, 1'b1, 1'b0, 2'd0};
        vecs[5]  = '{1'b0, 1'b1, 1, 2'd2, 1'b0, 1'b1, 1'b0, 2'd0};
        vecs[6]  = '{1'b0, 1'b1, 3, 2'd2, 1'b0, 1'b1, 1'b0, 2'd0};
        vecs[7]  = '{1'b0, 1'b1, 1, 2'd3, 1'b0, 1'b0, 1'b1, 2'd0};
        // Loss in RUN: low sampled at edge 25, HOLD after 27, relock N=26
        vecs[8]  = '{1'b0, 1'b0, 1, 2'd3, 1'b0, 1'b0, 1'b1, 2'd0};
        vecs[9]  = '{1'b0, 1'b1, 1, 2'd3, 1'b0, 1'b0, 1'b1, 2'd0};
        vecs[10] = '{1'b0, 1'b1, 1, 2'd0, 1'b1, 1'b1, 1'b0, 2'd1};
        vecs[11] = '{1'b0, 1'b1, 1, 2'd1, 1'b1, 1'b1, 1'b0, 2'd1};
        vecs[12] = '{1'b0, 1'b1, 8, 2'd2, 1'b0, 1'b1, 1'b0, 2'd1};
        vecs[13] = '{1'b0, 1'b1, 4, 2'd3, 1'b0, 1'b0, 1'b1, 2'd1};
        // Reset at edge 41, then unstable lock: high 42..46, low 47, high from 48
        vecs[14] = '{1'b1, 1'b1, 1, 2'd0, 1'b1, 1'b1, 1'b0, 2'd0};
        vecs[15] = '{1'b0, 1'b1, 5, 2'd1, 1'b1, 1'b1, 1'b0, 2'd0};
        vecs[16] = '{1'b0, 1'b0, 1, 2'd1, 1'b1, 1'b1, 1'b0, 2'd0};
        vecs[17] = '{1'b0, 1'b1, 1, 2'd1, 1'b1, 1'b1, 1'b0, 2'd0};
        vecs[18] = '{1'b0, 1'b1, 1, 2'd0, 1'b1, 1'b1, 1'b0, 2'd0};
        vecs[19] = '{1'b0, 1'b1, 1, 2'd1, 1'b1, 1'b1, 1'b0, 2'd0};
        vecs[20] = '{1'b0, 1'b1, 7, 2'd1, 1'b1, 1'b1, 1'b0, 2'd0};
        vecs[21] = '{1'b0, 1'b1, 1, 2'd2, 1'b0, 1'b1, 1'b0, 2'd0};
        vecs[22] = '{1'b0, 1'b1, 3, 2'd2, 1'b0, 1'b1, 1'b0, 2'd0};
        vecs[23] = '{1'b0, 1'b1, 1, 2'd3, 1'b0, 1'b0, 1'b1, 2'd0};

        for (int i = 0; i < 24; i++) begin
            rst    = vecs[i].rst;
            locked = vecs[i].locked;
            step(vecs[i].cycles);
            check($sformatf("vec%0d", i), vecs[i].st, vecs[i].core, vecs[i].periph,
                  vecs[i].rdy, vecs[i].loss);
        end

        // Terminal-count collision in STAGE
        locked = 1'b0;
        step(3);
        check("drop_run", 2'd0, 1'b1, 1'b1, 1'b0, 2'd1);
        locked = 1'b1;
        wait_state("reach_stage", 2'd2, 40);
        step(1);
        locked = 1'b0;
        step(2);
        check("stage_last", 2'd2, 1'b0, 1'b1, 1'b0, 2'd1);
        step(1);
        check("collision", 2'd0, 1'b1, 1'b1, 1'b0, 2'd2);

        // Mid-run reset with two losses recorded
        locked = 1'b1;
        wait_state("reach_run", 2'd3, 40);
        check("run_loss2", 2'd3, 1'b0, 1'b0, 1'b1, 2'd2);
        rst = 1'b1;
        step(1);
        check("midrun_rst", 2'd0, 1'b1, 1'b1, 1'b0, 2'd0);
        rst = 1'b0;
        step(2);
        check("rerel_n1", 2'd0, 1'b1, 1'b1, 1'b0, 2'd0);
        step(1);
        check("rerel_n2", 2'd1, 1'b1, 1'b1, 1'b0, 2'd0);
        step(7);
        check("rerel_n9", 2'd1, 1'b1, 1'b1, 1'b0, 2'd0);
        step(1);
        check("rerel_n10", 2'd2, 1'b0, 1'b1, 1'b0, 2'd0);
        step(3);
        check("rerel_n13", 2'd2, 1'b0, 1'b1, 1'b0, 2'd0);
        step(1);
        check("rerel_n14", 2'd3, 1'b0, 1'b0, 1'b1, 2'd0);

        // Saturation: five RUN->HOLD losses
        for (int k = 0; k < 5; k++) begin
            logic [1:0] exp_loss;
            exp_loss = (k >= 2) ? 2'd3 : 2'(k + 1);
            locked = 1'b0;
            step(3);
            check($sformatf("sat%0d", k), 2'd0, 1'b1, 1'b1, 1'b0, exp_loss);
            locked = 1'b1;
            wait_state($sformatf("sat_run%0d", k), 2'd3, 40);
        end

        // Sub-cycle glitch between edges is never sampled
        #2 locked = 1'b0;
        #2 locked = 1'b1;
        step(4);
        check("glitch", 2'd3, 1'b0, 1'b0, 1'b1, 2'd3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
